hdcp_key_reader: RTL

HDCP_KEY_READER -- requirements
Module: hdcp_key_reader

---
 rtl/hdcp_key_reader_if.sv | 24 ++
 rtl/hdcp_key_reader.sv | 115 +++++++++++
 2 files changed

// File: rtl/hdcp_key_reader_if.sv
// Key RAM read port plus the outgoing key-word stream, bundled for the reader.
interface hdcp_key_reader_if #(
    parameter int DATA_WIDTH = 64,
    parameter int AW         = 6
);
    logic                  ram_en;
    logic                  ram_regce;
    logic [AW-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic [DATA_WIDTH-1:0] key_data;
    logic                  key_last;
    logic                  key_valid;
    logic                  key_ready;

    modport master (
        output ram_en, ram_regce, ram_addr, key_data, key_last, key_valid,
        input  ram_dout, key_ready
    );

    modport slave (
        input  ram_en, ram_regce, ram_addr, key_data, key_last, key_valid,
        output ram_dout, key_ready
    );
endinterface

// File: rtl/hdcp_key_reader.sv
// Burst reader for a 2-cycle-latency key RAM, streaming words through a 4-deep FIFO
// with credit-based issue so the FIFO can never overflow.
module hdcp_key_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 64,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   word_cnt,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    hdcp_key_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t                state, state_nxt;
    logic [AW-1:0]         addr;
    logic [AW:0]           remaining;
    logic                  zero_burst;
    logic                  en_d1, en_d2, last_d1, last_d2;
    logic [1:0]            inflight;
    logic [DATA_WIDTH-1:0] fifo_data [4];
    logic                  fifo_last [4];
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            fifo_count;
    logic                  accept, issue, pop, push, finish, flush_fifo;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = FETCH;
            FETCH:   if (abort) state_nxt = FLUSH;
                     else if (finish) state_nxt = IDLE;
            FLUSH:   if (inflight == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Issue only while every outstanding word (buffered, in flight, and this one) fits.
    always_comb begin
        inflight      = {1'b0, en_d1} + {1'b0, en_d2};
        accept        = (state == IDLE) && start && (inflight == 2'd0);
        issue         = (state == FETCH) && !abort && (remaining != '0) &&
                        ((4'(fifo_count) + 4'(inflight)) < 4'd4);
        bus.key_valid = (fifo_count != 3'd0);
        bus.key_data  = bus.key_valid ? fifo_data[rd_ptr] : '0;
        bus.key_last  = bus.key_valid && fifo_last[rd_ptr];
        pop           = bus.key_valid && bus.key_ready;
        flush_fifo    = (state == FETCH) && abort;
        push          = en_d2 && (state == FETCH) && !abort;
        finish        = (state == FETCH) && !abort && (zero_burst || (pop && bus.key_last));
        done          = finish;
        busy          = (state != IDLE);
        bus.ram_en    = issue;
        bus.ram_addr  = addr;
        bus.ram_regce = en_d1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr       <= '0;
            remaining  <= '0;
            zero_burst <= 1'b0;
            en_d1      <= 1'b0;
            en_d2      <= 1'b0;
            last_d1    <= 1'b0;
            last_d2    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            en_d1   <= issue;
            last_d1 <= issue && (remaining == (AW+1)'(1));
            en_d2   <= en_d1;
            last_d2 <= last_d1;
            if (accept) begin
                addr       <= base_addr;
                remaining  <= word_cnt;
                zero_burst <= (word_cnt == '0);
            end else if (issue) begin
                addr      <= (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
                remaining <= remaining - (AW+1)'(1);
            end
            if (flush_fifo) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 2'd1;
                if (pop)  rd_ptr <= rd_ptr + 2'd1;
                unique case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + 3'd1;
                    2'b01:   fifo_count <= fifo_count - 3'd1;
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush_fifo) begin
            fifo_data[wr_ptr] <= bus.ram_dout;
            fifo_last[wr_ptr] <= last_d2;
        end
    end
endmodule
